vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing source for the video pipeline. It produces the hcount/vcount, sync and blanking stream that feeds the overlay and draw stages downstream, so it is the transmitting end of that interface. Free-running horizontal and vertical counters advance on a pixel-enable strobe. All outputs are registered and mutually aligned, so every downstream stage sees a zero-skew, one-pixel-coherent timing bundle.

## Interface
- `CW`, 11: counter width; must hold `H_TOTAL-1` and `V_TOTAL-1`
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: hsync width
- `H_BP`, 48: horizontal back porch (`H_TOTAL` = sum of the four = 800)
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vsync width
- `V_BP`, 33: vertical back porch (`V_TOTAL` = 525)
- `SYNC_POL`, 0: asserted level of hsync/vsync (0 = active-low)
- `pclk` in 1: pixel clock
- `rst_n` in 1: asynchronous, active-low reset
- `pix_en` in 1: advance strobe; counters move only on cycles where it is high
- `hcount_out` out CW: current pixel column
- `vcount_out` out CW: current line
- `hsync_out` out 1: horizontal sync, level per `SYNC_POL`
- `vsync_out` out 1: vertical sync, level per `SYNC_POL`
- `hblnk_out` out 1: high when `hcount_out >= H_ACTIVE`
- `vblnk_out` out 1: high when `vcount_out >= V_ACTIVE`
- `line_start` out 1: one-cycle pulse when `hcount_out` becomes 0
- `frame_start` out 1: one-cycle pulse when (`hcount_out`, `vcount_out`) becomes (0,0)
- `frame_cnt` out 16: frames completed (present only with `VGA_TIMING_FRAME_CNT_EN`)

## Operation
- **Horizontal counter.** On a `pix_en` edge, if `h == H_TOTAL-1` then `h <= 0`; otherwise `h <= h+1`.
- **Vertical counter.** Advances only on the horizontal wrap. If `v == V_TOTAL-1` then `v <= 0`; otherwise `v <= v+1`.
- **Output decode.**
  - Sync, blank and pulse outputs are decoded from the *next* counter values.
  - They are registered on the same edge as the counters, so every output describes the `hcount_out`/`vcount_out` it is registered with.
- **Sync windows.**
  - hsync is asserted for `H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC` (656..751 with defaults).
  - vsync is asserted for `V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC` (490..491 with defaults).
- **Start pulses.** `line_start` and `frame_start` are high exactly one `pclk` cycle: the cycle after the advancing edge. They are low whenever `pix_en` was low on the previous edge.
- **Stall.** While `pix_en` is low, all counters and levels hold. No pulses are generated.
- **Arithmetic.** Window bounds are elaborated as `CW`-bit constants. Comparisons are unsigned, with no wrap-around other than the explicit terminal-count wrap.

## Timing
- **Reset values** (`rst_n` low, asynchronous):
  - `hcount_out` = 0, `vcount_out` = 0
  - `hblnk_out` = 0, `vblnk_out` = 0
  - `hsync_out` = `vsync_out` = `~SYNC_POL` (deasserted)
  - `line_start` = 0, `frame_start` = 0
  - `frame_cnt` = 0
- **Reset release.** The first `pix_en` edge after release moves the counters to (1,0). No `frame_start` is issued for the reset-entered (0,0).
- **Reset mid-frame.** Outputs return to the reset values immediately, without waiting for a clock edge. Any in-progress sync pulse is truncated.
- **Latency.** Zero cycles from counter state to outputs: all outputs are registered together. Downstream stages add their own register delay.
- **Simultaneous wraps.** At `h = H_TOTAL-1` and `v = V_TOTAL-1`, one `pix_en` edge yields (0,0) with `line_start` = 1, `frame_start` = 1, and `frame_cnt` incremented.

## Configuration
- **`VGA_TIMING_FRAME_CNT_EN` defined:**
  - `frame_cnt` port and register exist.
  - It increments on each `frame_start` and wraps from 65535 to 0.
- **Undefined:**
  - Port and register are absent.
  - All other behaviour is identical.

## Test plan
- **Reset hold.** Hold `rst_n` = 0 with `pix_en` = 1 -> outputs stay at reset values. After release, the next edge gives `hcount_out` = 1, `vcount_out` = 0.
- **Line timing.** Run `pix_en` = 1 continuously:
  - `hblnk_out` rises at `hcount_out` = 640.
  - `hsync_out` is low for `hcount_out` 656..751 (96 cycles).
  - At 799 -> 0, `vcount_out` increments and `line_start` pulses once.
- **Frame wrap.** Run to `vcount_out` = 524, `hcount_out` = 799 -> next edge gives (0,0), `frame_start` = 1 for one cycle, and vsync is low only on lines 490..491.
- **Stall.** Pulse `pix_en` with a 1-in-2 duty -> counters advance every other cycle; the line period is 1600 `pclk` and pulses remain one cycle wide.
- **Asynchronous reset mid-frame.** Assert `rst_n` low mid-frame at (700,300) during hsync, between clock edges -> outputs reach reset values before the next edge and `hsync_out` deasserts.
- **Frame counter.** With `VGA_TIMING_FRAME_CNT_EN`, run 3 frames -> `frame_cnt` = 3. Force 65535 and run one frame -> `frame_cnt` = 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster timing source (hcount/vcount, sync, blanking, start pulses).
// Optional frame counter output is enabled by defining VGA_TIMING_FRAME_CNT_EN.
// All outputs are registered together, so each one describes the hcount/vcount it leaves with.
module vga_timing_gen #(
  parameter int unsigned CW       = 11,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [CW-1:0] hcount_out,
  output logic [CW-1:0] vcount_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          hblnk_out,
  output logic          vblnk_out,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  // Window bounds as CW-bit constants; all comparisons below are unsigned.
  localparam logic [CW-1:0] HTotalM1   = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] VTotalM1   = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] HActive    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActive    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HSyncStart = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HSyncEnd   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VSyncStart = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VSyncEnd   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          hblnk_q, hblnk_d;
  logic          vblnk_q, vblnk_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt_q, frame_cnt_d;
`endif

  // Next counter values, and every output decoded from those next values.
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    hblnk_d       = hblnk_q;
    vblnk_d       = vblnk_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    frame_cnt_d   = frame_cnt_q;
`endif
    if (pix_en) begin
      if (h_q == HTotalM1) begin
        h_d = '0;
        if (v_q == VTotalM1) begin
          v_d = '0;
        end else begin
          v_d = v_q + CW'(1);
        end
      end else begin
        h_d = h_q + CW'(1);
      end
      hblnk_d       = (h_d >= HActive);
      vblnk_d       = (v_d >= VActive);
      hsync_d       = ((h_d >= HSyncStart) && (h_d < HSyncEnd)) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = ((v_d >= VSyncStart) && (v_d < VSyncEnd)) ? SYNC_POL : ~SYNC_POL;
      line_start_d  = (h_d == '0);
      frame_start_d = (h_d == '0) && (v_d == '0);
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_cnt_d   = frame_cnt_q + 16'(frame_start_d);
`endif
    end
  end

  // Timing state register; reset puts the raster at (0,0) with syncs deasserted.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign hcount_out  = h_q;
  assign vcount_out  = v_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign hblnk_out   = hblnk_q;
  assign vblnk_out   = vblnk_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
  assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen.
// Horizontal timing is the default 800-pixel line; vertical timing is shortened to 15 lines so
// whole frames fit in the run. The frame counter is exercised when VGA_TIMING_FRAME_CNT_EN is set.
module tb_vga_timing_gen;

  localparam int unsigned CW       = 11;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 8;
  localparam int unsigned V_FP     = 2;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 3;
  localparam bit          SYNC_POL = 1'b0;
  localparam int unsigned HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned FRAME    = HT * VT;

  logic          pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_en = 1'b0;
  logic [CW-1:0] hcount_out, vcount_out;
  logic          hsync_out, vsync_out, hblnk_out, vblnk_out, line_start, frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
  int unsigned   fc_base = 0;
`endif

  int errors = 0;
  int checks = 0;

  vga_timing_gen #(
    .CW(CW), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_POL(SYNC_POL)
  ) dut (
    .pclk(pclk),
    .rst_n(rst_n),
    .pix_en(pix_en),
    .hcount_out(hcount_out),
    .vcount_out(vcount_out),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out),
    .hblnk_out(hblnk_out),
    .vblnk_out(vblnk_out),
    .line_start(line_start),
    .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  always #5 pclk = ~pclk;

  // Reference model: the raster position is just the number of enabled edges since reset.
  int unsigned n_m;
  bit          ep_m;
  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      n_m  <= 0;
      ep_m <= 1'b0;
    end else begin
      if (pix_en) n_m <= n_m + 1;
      ep_m <= pix_en;
    end
  end

  function automatic logic [2*CW+5:0] exp_bundle(int unsigned n, bit ep);
    int unsigned h, v;
    logic hs, vs, ls, fs;
    h  = n % HT;
    v  = (n / HT) % VT;
    hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
    vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;
    ls = ep && (h == 0);
    fs = ls && (v == 0);
    return {CW'(h), CW'(v), hs, vs, (h >= H_ACTIVE), (v >= V_ACTIVE), ls, fs};
  endfunction

  logic [2*CW+5:0] act;
  assign act = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                line_start, frame_start};

  task automatic test_reset();
    logic [2*CW+5:0] rst_b;
    rst_b  = {CW'(0), CW'(0), ~SYNC_POL, ~SYNC_POL, 4'b0000};
    rst_n  = 1'b0;
    pix_en = 1'b1;
    repeat (5) begin
      @(negedge pclk);
      checks++;
      if (act !== rst_b) begin
        errors++;
        $display("FAIL reset_hold: got %h want %h", act, rst_b);
      end
    end
    rst_n = 1'b1;
    @(negedge pclk);
    checks++;
    if (hcount_out !== CW'(1) || vcount_out !== CW'(0) || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got h=%0d v=%0d fs=%b want h=1 v=0 fs=0",
               hcount_out, vcount_out, frame_start);
    end
  endtask

  task automatic test_line_timing();
    int rise_h = -1;
    int hs_cnt = 0;
    int ls_cnt = 0;
    logic prev_hb = 1'b0;
    pix_en = 1'b1;
    repeat (1700) begin
      @(negedge pclk);
      checks++;
      if (act !== exp_bundle(n_m, ep_m)) begin
        errors++;
        $display("FAIL line_model: got %h want %h", act, exp_bundle(n_m, ep_m));
      end
      if (hblnk_out && !prev_hb && rise_h < 0) rise_h = int'(hcount_out);
      prev_hb = hblnk_out;
      if (vcount_out == CW'(1) && hsync_out == SYNC_POL) hs_cnt++;
      if (line_start && hcount_out == CW'(0) && vcount_out == CW'(1)) ls_cnt++;
    end
    checks++;
    if (rise_h != H_ACTIVE) begin
      errors++;
      $display("FAIL hblnk_rise: got %0d want %0d", rise_h, H_ACTIVE);
    end
    checks++;
    if (hs_cnt != H_SYNC) begin
      errors++;
      $display("FAIL hsync_width: got %0d want %0d", hs_cnt, H_SYNC);
    end
    checks++;
    if (ls_cnt != 1) begin
      errors++;
      $display("FAIL line_start_v1: got %0d want 1", ls_cnt);
    end
  endtask

  task automatic test_frame_wrap();
    int unsigned cycles;
    int vs_cnt = 0;
    int fs_cnt = 0;
    int vs_bad = 0;
    logic [CW-1:0] ph = '0, pv = '0;
    pix_en = 1'b1;
    cycles = FRAME - (n_m % FRAME) + 10;
    repeat (cycles) begin
      @(negedge pclk);
      checks++;
      if (act !== exp_bundle(n_m, ep_m)) begin
        errors++;
        $display("FAIL frame_model: got %h want %h", act, exp_bundle(n_m, ep_m));
      end
      if (vsync_out == SYNC_POL) begin
        vs_cnt++;
        if (vcount_out < CW'(V_ACTIVE + V_FP) || vcount_out >= CW'(V_ACTIVE + V_FP + V_SYNC))
          vs_bad++;
      end
      if (frame_start) begin
        fs_cnt++;
        checks++;
        if (ph !== CW'(HT - 1) || pv !== CW'(VT - 1) || hcount_out !== '0 ||
            vcount_out !== '0 || line_start !== 1'b1) begin
          errors++;
          $display("FAIL frame_wrap: prev=(%0d,%0d) now=(%0d,%0d) ls=%b want (%0d,%0d)->(0,0) ls=1",
                   ph, pv, hcount_out, vcount_out, line_start, HT - 1, VT - 1);
        end
      end
      ph = hcount_out;
      pv = vcount_out;
    end
    checks++;
    if (fs_cnt != 1) begin
      errors++;
      $display("FAIL frame_start_count: got %0d want 1", fs_cnt);
    end
    checks++;
    if (vs_cnt != int'(V_SYNC * HT) || vs_bad != 0) begin
      errors++;
      $display("FAIL vsync_window: got %0d cycles (%0d outside) want %0d", vs_cnt, vs_bad,
               V_SYNC * HT);
    end
  endtask

  task automatic test_stall();
    int first = -1;
    int period = -1;
    pix_en = 1'b1;
    for (int c = 0; c < 4000 && period < 0; c++) begin
      @(negedge pclk);
      checks++;
      if (act !== exp_bundle(n_m, ep_m)) begin
        errors++;
        $display("FAIL stall_model: got %h want %h", act, exp_bundle(n_m, ep_m));
      end
      if (line_start === 1'b1) begin
        if (first < 0) first = c;
        else period = c - first;
      end
      pix_en = ~pix_en;
    end
    checks++;
    if (period != int'(2 * HT)) begin
      errors++;
      $display("FAIL stall_line_period: got %0d want %0d", period, 2 * HT);
    end
    pix_en = 1'b1;
  endtask

  task automatic test_random_stall();
    repeat (3000) begin
      @(negedge pclk);
      checks++;
      if (act !== exp_bundle(n_m, ep_m)) begin
        errors++;
        $display("FAIL random_stall: got %h want %h", act, exp_bundle(n_m, ep_m));
      end
      pix_en = 1'($urandom_range(0, 1));
    end
    pix_en = 1'b1;
  endtask

  task automatic test_async_reset();
    int unsigned target;
    int guard = 0;
    logic [2*CW+5:0] rst_b;
    rst_b  = {CW'(0), CW'(0), ~SYNC_POL, ~SYNC_POL, 4'b0000};
    target = 5 * HT + 700;
    pix_en = 1'b1;
    @(negedge pclk);
    while ((n_m % FRAME) != target && guard < int'(2 * FRAME)) begin
      @(negedge pclk);
      guard++;
    end
    checks++;
    if (hcount_out !== CW'(700) || vcount_out !== CW'(5) || hsync_out !== SYNC_POL) begin
      errors++;
      $display("FAIL async_pre: got h=%0d v=%0d hs=%b want h=700 v=5 hs=%b",
               hcount_out, vcount_out, hsync_out, SYNC_POL);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (act !== rst_b) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", act, rst_b);
    end
    @(negedge pclk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge pclk);
      checks++;
      if (act !== exp_bundle(n_m, ep_m)) begin
        errors++;
        $display("FAIL post_reset: got %h want %h", act, exp_bundle(n_m, ep_m));
      end
    end
  endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
  task automatic test_frame_cnt();
    rst_n   = 1'b0;
    pix_en  = 1'b1;
    @(negedge pclk);
    rst_n   = 1'b1;
    fc_base = 0;
    repeat (3 * FRAME + 2) begin
      @(negedge pclk);
      checks++;
      if (frame_cnt !== 16'(fc_base + n_m / FRAME)) begin
        errors++;
        $display("FAIL frame_cnt_run: got %0d want %0d", frame_cnt, 16'(fc_base + n_m / FRAME));
      end
    end
    checks++;
    if (frame_cnt !== 16'd3) begin
      errors++;
      $display("FAIL frame_cnt_3: got %0d want 3", frame_cnt);
    end
    pix_en = 1'b0;
    @(negedge pclk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge pclk);
    release dut.frame_cnt_q;
    fc_base = 32'd65535 - n_m / FRAME;
    pix_en  = 1'b1;
    repeat (FRAME) @(negedge pclk);
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL frame_cnt_wrap: got %0d want 0", frame_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_line_timing();
    test_frame_wrap();
    test_stall();
    test_random_stall();
    test_async_reset();
`ifdef VGA_TIMING_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
